// File: rtl/clause_ctrl_pkg.sv
// Shared types and constants for the clause controller and its lit-cell chain interface.
package clause_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StDecide,
    StImply,
    StVerify,
    StConflict,
    StAnalyze
  } state_e;

  localparam logic [1:0] FLC_NONE = 2'd0;
  localparam logic [1:0] FLC_ONE  = 2'd1;
  localparam logic [1:0] FLC_MANY = 2'd2;

  localparam int unsigned IMP_CNT_W = 8;

  // Both encodings 2 and 3 mean "two or more free literals".
  function automatic logic flc_is_many(logic [1:0] flc);
    return flc >= FLC_MANY;
  endfunction

endpackage

// File: rtl/clause_ctrl_if.sv
// Control/result bundle between the clause controller and its lit-cell chain.
interface clause_ctrl_if;
  import clause_ctrl_pkg::*;

  logic                 start_i;
  logic                 flush_i;
  logic [1:0]           freelitcnt_i;
  logic                 clausesat_i;
  logic                 analyze_i;
  logic                 imp_drv_o;
  logic                 cclause_drv_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 sat_o;
  logic                 implied_o;
  logic                 conflict_o;
  logic                 error_o;
  logic [IMP_CNT_W-1:0] imp_cnt_o;

  modport master (
    output start_i, flush_i, freelitcnt_i, clausesat_i, analyze_i,
    input  imp_drv_o, cclause_drv_o, busy_o, done_o, sat_o, implied_o, conflict_o, error_o,
    input  imp_cnt_o
  );

  modport slave (
    input  start_i, flush_i, freelitcnt_i, clausesat_i, analyze_i,
    output imp_drv_o, cclause_drv_o, busy_o, done_o, sat_o, implied_o, conflict_o, error_o,
    output imp_cnt_o
  );

endinterface

// File: rtl/clause_ctrl_cycle_timer.sv
// 4-bit down-counter: load_i presets the count, expire_o is high once it has reached zero.
module cycle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       expire_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 4'd0);

endmodule

// File: rtl/clause_ctrl.sv
// Clause evaluation controller: settles the lit-cell chain, decides sat/imply/conflict and
// sequences implication and conflict analysis. All outputs are registered.
module clause_ctrl
  import clause_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned IMP_HOLD_CYCLES = 1
) (
  input logic          clk,
  input logic          rst,
  clause_ctrl_if.slave bus
);

  // Timer counts down to zero, so a wait of N cycles loads N-1.
  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] HoldLoad   = 4'(IMP_HOLD_CYCLES - 1);

  state_e state_q, state_d;
  logic   hold_done_q, hold_done_d;  // IMPLY sub-phase: 0 = driving, 1 = settling

  logic       tmr_load;
  logic [3:0] tmr_val;
  logic       tmr_expire;

  logic imp_drv_q, imp_drv_d;
  logic cclause_q, cclause_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic sat_q, sat_d;
  logic implied_q, implied_d;
  logic conflict_q, conflict_d;
  logic error_q, error_d;
  logic [IMP_CNT_W-1:0] imp_cnt_q, imp_cnt_d;

  cycle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    hold_done_d = hold_done_q;
    tmr_load    = 1'b0;
    tmr_val     = SettleLoad;
    done_d      = 1'b0;
    sat_d       = 1'b0;
    implied_d   = 1'b0;
    error_d     = 1'b0;
    imp_cnt_d   = imp_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d  = StSettle;
          tmr_load = 1'b1;
        end
      end
      StSettle: begin
        if (tmr_expire) state_d = StDecide;
      end
      StDecide: begin
        if (bus.clausesat_i) begin
          state_d = StIdle;
          done_d  = 1'b1;
          sat_d   = 1'b1;
        end else if (bus.freelitcnt_i == FLC_NONE) begin
          state_d = StConflict;
        end else if (bus.freelitcnt_i == FLC_ONE) begin
          state_d     = StImply;
          hold_done_d = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = HoldLoad;
        end else if (flc_is_many(bus.freelitcnt_i)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StImply: begin
        if (tmr_expire) begin
          if (!hold_done_q) begin
            hold_done_d = 1'b1;
            tmr_load    = 1'b1;
          end else begin
            state_d = StVerify;
          end
        end
      end
      StVerify: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (bus.clausesat_i) begin
          implied_d = 1'b1;
          if (imp_cnt_q != '1) imp_cnt_d = imp_cnt_q + 1'b1;
        end else begin
          error_d = 1'b1;
        end
      end
      StConflict: begin
        if (bus.analyze_i) state_d = StAnalyze;
      end
      StAnalyze: begin
        if (!bus.analyze_i) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush_i) begin
      state_d   = StIdle;
      tmr_load  = 1'b0;
      done_d    = 1'b0;
      sat_d     = 1'b0;
      implied_d = 1'b0;
      error_d   = 1'b0;
      imp_cnt_d = imp_cnt_q;
    end

    // Level outputs follow the next state so they line up with it after the edge.
    imp_drv_d  = (state_d == StImply) && !hold_done_d;
    cclause_d  = (state_d == StAnalyze);
    conflict_d = (state_d == StConflict) || (state_d == StAnalyze);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      hold_done_q <= 1'b0;
      imp_drv_q   <= 1'b0;
      cclause_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      implied_q   <= 1'b0;
      conflict_q  <= 1'b0;
      error_q     <= 1'b0;
      imp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_done_q <= hold_done_d;
      imp_drv_q   <= imp_drv_d;
      cclause_q   <= cclause_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      implied_q   <= implied_d;
      conflict_q  <= conflict_d;
      error_q     <= error_d;
      imp_cnt_q   <= imp_cnt_d;
    end
  end

  assign bus.imp_drv_o     = imp_drv_q;
  assign bus.cclause_drv_o = cclause_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.sat_o         = sat_q;
  assign bus.implied_o     = implied_q;
  assign bus.conflict_o    = conflict_q;
  assign bus.error_o       = error_q;
  assign bus.imp_cnt_o     = imp_cnt_q;

endmodule

// File: tb/tb_clause_ctrl.sv
// Directed bench for clause_ctrl at default parameters (SETTLE_CYCLES=2, IMP_HOLD_CYCLES=1).
module tb_clause_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  clause_ctrl_if bus ();

  clause_ctrl #(
    .SETTLE_CYCLES   (2),
    .IMP_HOLD_CYCLES (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {bus.imp_drv_o, bus.cclause_drv_o, bus.busy_o, bus.done_o,
            bus.sat_o, bus.implied_o, bus.conflict_o, bus.error_o};
  endfunction

  // Pulse start and run until done_o; optionally model the lit cells satisfying the
  // clause once the implication drive has been seen.
  task automatic run_eval(input logic [1:0] flc, input logic cs, input logic model,
                          output int lat, output logic [2:0] flags, output int imp_cyc);
    bus.freelitcnt_i = flc;
    bus.clausesat_i  = cs;
    bus.start_i      = 1'b1;
    lat     = 0;
    imp_cyc = 0;
    flags   = 3'b000;
    for (int i = 0; i < 40; i++) begin
      tick();
      bus.start_i = 1'b0;
      lat++;
      if (bus.imp_drv_o) begin
        imp_cyc++;
        if (model) bus.clausesat_i = 1'b1;
      end
      if (bus.done_o) begin
        flags = {bus.sat_o, bus.implied_o, bus.error_o};
        break;
      end
    end
    bus.clausesat_i = 1'b0;
  endtask

  // Drive an evaluation into CONFLICT; returns cycles until conflict_o rose.
  task automatic go_conflict(output int lat);
    bus.freelitcnt_i = 2'd0;
    bus.clausesat_i  = 1'b0;
    bus.start_i      = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      bus.start_i = 1'b0;
      lat++;
      if (bus.conflict_o) break;
    end
  endtask

  int         lat;
  int         imp_cyc;
  int         cc_cyc;
  int         seen_done;
  logic [2:0] flags;

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.start_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.freelitcnt_i = 2'd0;
    bus.clausesat_i  = 1'b0;
    bus.analyze_i    = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset_outs", 32'(outs()), 32'h0);
    check("reset_cnt", 32'(bus.imp_cnt_o), 32'd0);
    tick();
    tick();
    #2 rst = 1'b1;
    tick();

    // Satisfied clause: done+sat at SETTLE_CYCLES+2
    run_eval(2'd2, 1'b1, 1'b0, lat, flags, imp_cyc);
    check("sat_lat", 32'(lat), 32'd4);
    check("sat_flags", 32'(flags), 32'b100);
    tick();
    check("sat_pulse_end", 32'(outs()), 32'h0);

    // Undetermined: two free literals
    run_eval(2'd3, 1'b0, 1'b0, lat, flags, imp_cyc);
    check("undet_lat", 32'(lat), 32'd4);
    check("undet_flags", 32'(flags), 32'b000);

    // Successful implication
    run_eval(2'd1, 1'b0, 1'b1, lat, flags, imp_cyc);
    check("imp_lat", 32'(lat), 32'd8);
    check("imp_drv_cycles", 32'(imp_cyc), 32'd1);
    check("imp_flags", 32'(flags), 32'b010);
    check("imp_cnt_1", 32'(bus.imp_cnt_o), 32'd1);
    tick();
    check("imp_pulse_end", 32'(outs()), 32'h0);

    // Implication that fails to satisfy the clause
    run_eval(2'd1, 1'b0, 1'b0, lat, flags, imp_cyc);
    check("err_lat", 32'(lat), 32'd8);
    check("err_flags", 32'(flags), 32'b001);
    check("err_cnt", 32'(bus.imp_cnt_o), 32'd1);

    // Conflict and analysis with analyze_i high for 3 cycles
    go_conflict(lat);
    check("conf_lat", 32'(lat), 32'd4);
    check("conf_outs", 32'(outs()), 32'b0010_0010);
    tick();
    tick();
    check("conf_hold", 32'(bus.conflict_o), 32'd1);
    bus.analyze_i = 1'b1;
    cc_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.cclause_drv_o) cc_cyc++;
      check("ana_conflict", 32'(bus.conflict_o), 32'd1);
      check("ana_no_imp", 32'(bus.imp_drv_o), 32'd0);
    end
    bus.analyze_i = 1'b0;
    check("ana_cc_cycles", 32'(cc_cyc), 32'd3);
    tick();
    check("ana_end", 32'(outs()), 32'b0001_0000);
    tick();

    // Flush during IMPLY
    bus.freelitcnt_i = 2'd1;
    bus.start_i      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.start_i = 1'b0;
      if (bus.imp_drv_o) break;
    end
    check("flush_in_imply", 32'(bus.imp_drv_o), 32'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("flush_outs", 32'(outs()), 32'h0);
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done_o || bus.busy_o) seen_done++;
    end
    check("flush_no_done", 32'(seen_done), 32'd0);
    check("flush_cnt", 32'(bus.imp_cnt_o), 32'd1);

    // Flush and start in the same idle cycle
    bus.flush_i = 1'b1;
    bus.start_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done_o || bus.busy_o) seen_done++;
      tick();
    end
    check("flush_start", 32'(seen_done), 32'd0);

    // Reset during ANALYZE drops cclause_drv_o without a clock edge
    go_conflict(lat);
    bus.analyze_i = 1'b1;
    tick();
    tick();
    check("pre_rst_cc", 32'(bus.cclause_drv_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_outs", 32'(outs()), 32'h0);
    check("rst_cnt", 32'(bus.imp_cnt_o), 32'd0);
    bus.analyze_i = 1'b0;
    tick();
    #2 rst = 1'b1;
    tick();
    check("post_rst_idle", 32'(outs()), 32'h0);

    // Saturation of imp_cnt_o
    for (int i = 0; i < 255; i++) begin
      run_eval(2'd1, 1'b0, 1'b1, lat, flags, imp_cyc);
    end
    check("cnt_255", 32'(bus.imp_cnt_o), 32'd255);
    run_eval(2'd1, 1'b0, 1'b1, lat, flags, imp_cyc);
    check("sat_imp_flags", 32'(flags), 32'b010);
    check("cnt_sat", 32'(bus.imp_cnt_o), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/clause_ctrl.md
CLAUSE_CTRL -- requirements
Module: clause_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: cycles allowed for the lit-cell freelitcnt/clausesat chain to settle, legal range 1..15.
REQ-002 The block SHALL have parameter IMP_HOLD_CYCLES, default 1: cycles imp_drv_o is held during an implication, legal range 1..15.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low; ports are clk and rst.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  pulse requesting evaluation of the clause after a var-value write.
REQ-007 flush_i  in  1  synchronous abort of any operation in progress.
REQ-008 freelitcnt_i  in  2  free-literal count from the last lit cell in the chain; 0=none, 1=one, 2 or 3=two or more.
REQ-009 clausesat_i  in  1  clause-satisfied OR of all lit cells.
REQ-010 analyze_i  in  1  conflict-analysis request; level-held.
REQ-011 imp_drv_o  out  1  drives all lit cells to imply the single free literal.
REQ-012 cclause_drv_o  out  1  drives lit cells to mark conflict-clause literals.
REQ-013 busy_o  out  1  high in any state except IDLE.
REQ-014 done_o  out  1  one-cycle pulse at the end of an evaluation.
REQ-015 sat_o, implied_o, conflict_o, error_o  out  1 each  result flags.
REQ-016 imp_cnt_o  out  8  saturating count of successful implications since reset.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, DECIDE, IMPLY, VERIFY, CONFLICT and ANALYZE.
REQ-018 IDLE + start_i SHALL enter SETTLE; start_i SHALL be ignored in every other state.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter DECIDE for exactly one cycle.
REQ-020 DECIDE SHALL use priority: clausesat_i=1 -> done_o+sat_o, IDLE; freelitcnt_i=0 -> CONFLICT; freelitcnt_i=1 -> IMPLY; freelitcnt_i>=2 -> done_o only, IDLE.
REQ-021 IMPLY SHALL assert imp_drv_o for exactly IMP_HOLD_CYCLES cycles, then wait SETTLE_CYCLES cycles with imp_drv_o low, then enter VERIFY.
REQ-022 VERIFY SHALL sample clausesat_i; on 1, pulse done_o+implied_o and increment imp_cnt_o (saturating at 255); on 0, pulse done_o+error_o; then IDLE.
REQ-023 CONFLICT SHALL hold conflict_o high; analyze_i=1 SHALL enter ANALYZE next cycle.
REQ-024 ANALYZE SHALL assert cclause_drv_o while analyze_i=1 and keep conflict_o high; on analyze_i=0, it SHALL pulse done_o and return to IDLE.
REQ-025 sat_o, implied_o and error_o SHALL be one-cycle pulses coincident with done_o; conflict_o SHALL be a level signal.
REQ-026 imp_drv_o and cclause_drv_o SHALL never be high in the same cycle.
REQ-027 flush_i SHALL take priority over all transitions: next state IDLE, all drives and flags low next cycle, no done_o; imp_cnt_o is unchanged.
REQ-028 flush_i in IDLE SHALL have no effect.
REQ-029 flush_i and start_i in the same IDLE cycle SHALL favour flush_i, so no evaluation starts.
REQ-030 All outputs SHALL be registered; the latency from start_i to done_o SHALL be SETTLE_CYCLES+2 cycles on the sat and undetermined paths.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, zero all counters and drive all outputs 0, including imp_cnt_o.
REQ-032 Reset asserted mid-IMPLY or mid-ANALYZE SHALL drop imp_drv_o or cclause_drv_o immediately, without waiting for a clock edge.

Structure
REQ-033 A shared package SHALL hold the state enum, the freelitcnt encoding constants (FLC_NONE, FLC_ONE, FLC_MANY) and the imp_cnt width.
REQ-034 A 4-bit down-counter sub-module, cycle_timer, SHALL provide the SETTLE and IMP_HOLD waits with load/expire handshake.

Verification
REQ-035 Defaults; start_i with clausesat_i=1 -> done_o+sat_o exactly 4 cycles after start_i.
REQ-036 freelitcnt_i=1, clausesat_i=0, model raises clausesat_i after imp_drv_o -> imp_drv_o high 1 cycle, done_o+implied_o later, imp_cnt_o 0->1.
REQ-037 freelitcnt_i=0, clausesat_i=0; analyze_i high 3 cycles -> conflict_o level, cclause_drv_o high 3 cycles, done_o after analyze_i falls.
REQ-038 Implication with clausesat_i held 0 -> error_o+done_o pulse, imp_cnt_o unchanged.
REQ-039 flush_i during IMPLY, and rst low during ANALYZE -> drives low (next cycle / immediately), IDLE, no done_o.
REQ-040 256 successful implications -> imp_cnt_o saturates at 255.
